// File: rtl/gravity_timer_if.sv
// Drop-request handshake between the gravity timer (master) and the piece-control FSM (slave).
interface gravity_timer_if;
    logic drop_req;
    logic drop_src;
    logic drop_ack;

    modport master (
        output drop_req,
        output drop_src,
        input  drop_ack
    );

    modport slave (
        input  drop_req,
        input  drop_src,
        output drop_ack
    );
endinterface

// File: rtl/gravity_timer.sv
// Turns game ticks and the soft-drop button into drop requests for the piece FSM,
// and keeps level / cleared-line bookkeeping from line-clear reports.
module gravity_timer #(
    parameter int unsigned BASE_TICKS      = 10,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned SOFT_CYCLES     = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic                 run,
    input  logic                 new_game,
    input  logic                 soft_drop,
    gravity_timer_if.master      drop,
    input  logic                 lines_valid,
    input  logic [2:0]           lines_num,
    output logic [4:0]           level,
    output logic [15:0]          lines_total,
    output logic                 level_up
);

    localparam int unsigned TW = $clog2(BASE_TICKS + 1);
    localparam int unsigned SW = $clog2(SOFT_CYCLES);
    localparam int unsigned AW = $clog2(LINES_PER_LEVEL + 4);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REQ
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] period;
    logic [TW:0]   tick_inc;
    logic [SW-1:0] soft_cnt;
    logic          grav_fire;
    logic          soft_fire;

    logic [AW-1:0] line_acc;
    logic [AW-1:0] acc_sum;
    logic [2:0]    n_lines;
    logic [16:0]   lines_sum;

    always_comb begin
        period    = TW'(BASE_TICKS) - TW'(level);
        tick_inc  = {1'b0, tick_cnt} + {{TW{1'b0}}, 1'b1};
        grav_fire = tick_en && (tick_inc >= {1'b0, period});
        soft_fire = soft_drop && (soft_cnt == SW'(SOFT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            drop.drop_req <= 1'b0;
            drop.drop_src <= 1'b0;
            tick_cnt      <= '0;
            soft_cnt      <= '0;
        end else if (new_game) begin
            state         <= run ? COUNT : IDLE;
            drop.drop_req <= 1'b0;
            tick_cnt      <= '0;
            soft_cnt      <= '0;
        end else if (!run) begin
            state         <= IDLE;
            drop.drop_req <= 1'b0;
            tick_cnt      <= '0;
            soft_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drop.drop_req <= 1'b0;
                    tick_cnt      <= '0;
                    soft_cnt      <= '0;
                    state         <= COUNT;
                end
                COUNT: begin
                    // Gravity takes priority when both sources expire on the same edge.
                    if (grav_fire || soft_fire) begin
                        state         <= REQ;
                        drop.drop_req <= 1'b1;
                        drop.drop_src <= ~grav_fire;
                        tick_cnt      <= '0;
                        soft_cnt      <= '0;
                    end else begin
                        if (tick_en)
                            tick_cnt <= tick_inc[TW-1:0];
                        soft_cnt <= soft_drop ? soft_cnt + SW'(1) : '0;
                    end
                end
                REQ: begin
                    tick_cnt <= '0;
                    soft_cnt <= '0;
                    if (drop.drop_ack) begin
                        state         <= COUNT;
                        drop.drop_req <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    drop.drop_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        n_lines   = (lines_num > 3'd4) ? 3'd4 : lines_num;
        lines_sum = {1'b0, lines_total} + {14'd0, n_lines};
        acc_sum   = line_acc + AW'(n_lines);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            level       <= '0;
            lines_total <= '0;
            line_acc    <= '0;
            level_up    <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (lines_valid) begin
                lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                // Accumulator keeps wrapping at max level so the line count stays consistent.
                if (acc_sum >= AW'(LINES_PER_LEVEL)) begin
                    line_acc <= acc_sum - AW'(LINES_PER_LEVEL);
                    if (level < 5'(MAX_LEVEL)) begin
                        level    <= level + 5'd1;
                        level_up <= 1'b1;
                    end
                end else begin
                    line_acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_gravity_timer.sv
// Directed bench for gravity_timer: tick/soft-drop requests, handshake, level and line bookkeeping.
module tb_gravity_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_en;
    logic        run;
    logic        new_game;
    logic        soft_drop;
    logic        lines_valid;
    logic [2:0]  lines_num;
    logic [4:0]  level;
    logic [15:0] lines_total;
    logic        level_up;

    gravity_timer_if drop_if ();

    gravity_timer #(
        .BASE_TICKS      (10),
        .MAX_LEVEL       (9),
        .LINES_PER_LEVEL (10),
        .SOFT_CYCLES     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .run         (run),
        .new_game    (new_game),
        .soft_drop   (soft_drop),
        .drop        (drop_if.master),
        .lines_valid (lines_valid),
        .lines_num   (lines_num),
        .level       (level),
        .lines_total (lines_total),
        .level_up    (level_up)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [2:0]  ln;
        logic [4:0]  lvl;
        logic [15:0] tot;
        logic        up;
    } vec_t;

    vec_t tbl [11];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   exp_tot;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // n ticks spaced 8 clk apart; returns just after the edge that sampled the last tick
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (7) step();
            tick_en = 1'b1;
            step();
            tick_en = 1'b0;
        end
    endtask

    task automatic ack();
        drop_if.drop_ack = 1'b1;
        step();
        drop_if.drop_ack = 1'b0;
    endtask

    task automatic line_event(input logic [2:0] n);
        lines_valid = 1'b1;
        lines_num   = n;
        step();
        lines_valid = 1'b0;
        lines_num   = 3'd0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'd4, 5'd0, 16'd4,  1'b0};
        tbl[1]  = '{1'b0, 3'd0, 5'd0, 16'd4,  1'b0};
        tbl[2]  = '{1'b1, 3'd4, 5'd0, 16'd8,  1'b0};
        tbl[3]  = '{1'b1, 3'd2, 5'd1, 16'd10, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 5'd1, 16'd10, 1'b0};
        tbl[5]  = '{1'b1, 3'd0, 5'd1, 16'd10, 1'b0};
        tbl[6]  = '{1'b1, 3'd4, 5'd1, 16'd14, 1'b0};
        tbl[7]  = '{1'b1, 3'd4, 5'd1, 16'd18, 1'b0};
        tbl[8]  = '{1'b1, 3'd4, 5'd2, 16'd22, 1'b1};
        tbl[9]  = '{1'b1, 3'd7, 5'd2, 16'd26, 1'b0};
        tbl[10] = '{1'b1, 3'd5, 5'd3, 16'd30, 1'b1};

        rst_n = 1'b0; tick_en = 1'b0; run = 1'b0; new_game = 1'b0; soft_drop = 1'b0;
        lines_valid = 1'b0; lines_num = 3'd0; drop_if.drop_ack = 1'b0;
        step();
        step();
        chk("rst_drop_req", 32'(drop_if.drop_req), 32'd0);
        chk("rst_drop_src", 32'(drop_if.drop_src), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_lines_total", 32'(lines_total), 32'd0);
        chk("rst_level_up", 32'(level_up), 32'd0);
        rst_n = 1'b1;

        // gravity at level 0 fires on the 10th tick
        run = 1'b1;
        step();
        tick_n(9);
        chk("grav_before_10th", 32'(drop_if.drop_req), 32'd0);
        tick_n(1);
        chk("grav_at_10th", 32'(drop_if.drop_req), 32'd1);
        chk("grav_src", 32'(drop_if.drop_src), 32'd0);
        repeat (3) step();
        chk("req_held_no_ack", 32'(drop_if.drop_req), 32'd1);
        ack();
        chk("req_cleared_by_ack", 32'(drop_if.drop_req), 32'd0);
        tick_n(9);
        chk("second_before_10th", 32'(drop_if.drop_req), 32'd0);
        tick_n(1);
        chk("second_at_10th", 32'(drop_if.drop_req), 32'd1);

        // long wait without ack: ticks must not queue up
        tick_n(25);
        chk("held_25_ticks", 32'(drop_if.drop_req), 32'd1);
        chk("held_src", 32'(drop_if.drop_src), 32'd0);
        ack();
        chk("ack_after_hold", 32'(drop_if.drop_req), 32'd0);
        tick_n(9);
        chk("no_burst_9_ticks", 32'(drop_if.drop_req), 32'd0);
        tick_n(1);
        chk("fresh_count_10th", 32'(drop_if.drop_req), 32'd1);
        ack();

        // soft drop with SOFT_CYCLES=4
        soft_drop = 1'b1;
        repeat (3) step();
        chk("soft_before_4", 32'(drop_if.drop_req), 32'd0);
        step();
        chk("soft_at_4", 32'(drop_if.drop_req), 32'd1);
        chk("soft_src", 32'(drop_if.drop_src), 32'd1);
        ack();
        chk("soft_ack", 32'(drop_if.drop_req), 32'd0);
        repeat (3) step();
        chk("soft_repeat_before", 32'(drop_if.drop_req), 32'd0);
        step();
        chk("soft_repeat_at_4", 32'(drop_if.drop_req), 32'd1);
        ack();
        repeat (2) step();
        soft_drop = 1'b0;
        repeat (6) step();
        chk("soft_release_no_req", 32'(drop_if.drop_req), 32'd0);

        // line events from table
        for (int i = 0; i < 11; i++) begin
            lines_valid = tbl[i].lv;
            lines_num   = tbl[i].ln;
            step();
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_total", i), 32'(lines_total), 32'(tbl[i].tot));
            chk($sformatf("tbl%0d_level_up", i), 32'(level_up), 32'(tbl[i].up));
        end
        lines_valid = 1'b0;
        lines_num   = 3'd0;

        // climb to max level: 60 more lines from level 3 with empty accumulator
        for (int i = 0; i < 15; i++) line_event(3'd4);
        step();
        chk("max_level", 32'(level), 32'd9);
        chk("max_total", 32'(lines_total), 32'd90);
        line_event(3'd4);
        chk("max_up_a", 32'(level_up), 32'd0);
        line_event(3'd4);
        chk("max_up_b", 32'(level_up), 32'd0);
        line_event(3'd2);
        chk("max_up_wrap", 32'(level_up), 32'd0);
        chk("max_level_held", 32'(level), 32'd9);
        chk("max_total_100", 32'(lines_total), 32'd100);

        // period 1 at max level: every tick drops
        tick_n(1);
        chk("period1_first", 32'(drop_if.drop_req), 32'd1);
        ack();
        tick_n(1);
        chk("period1_second", 32'(drop_if.drop_req), 32'd1);
        ack();

        // lines_total saturation
        exp_tot = 100;
        lines_valid = 1'b1;
        lines_num   = 3'd4;
        for (int i = 0; i < 16400; i++) begin
            step();
            exp_tot = (exp_tot + 4 > 65535) ? 65535 : exp_tot + 4;
        end
        lines_valid = 1'b0;
        lines_num   = 3'd0;
        step();
        chk("total_saturate", 32'(lines_total), 32'(exp_tot));

        // run=0 while requesting
        tick_n(1);
        chk("req_before_stop", 32'(drop_if.drop_req), 32'd1);
        run = 1'b0;
        step();
        chk("stop_drops_req", 32'(drop_if.drop_req), 32'd0);
        chk("stop_keeps_level", 32'(level), 32'd9);
        chk("stop_keeps_total", 32'(lines_total), 32'd65535);
        tick_n(2);
        chk("idle_ignores_ticks", 32'(drop_if.drop_req), 32'd0);

        // new_game restores level 0 and the 10-tick period
        new_game = 1'b1;
        run      = 1'b1;
        lines_valid = 1'b1;
        lines_num   = 3'd4;
        step();
        new_game = 1'b0;
        lines_valid = 1'b0;
        lines_num   = 3'd0;
        chk("ng_level", 32'(level), 32'd0);
        chk("ng_total", 32'(lines_total), 32'd0);
        chk("ng_req", 32'(drop_if.drop_req), 32'd0);
        tick_n(9);
        chk("ng_before_10th", 32'(drop_if.drop_req), 32'd0);
        tick_n(1);
        chk("ng_at_10th", 32'(drop_if.drop_req), 32'd1);
        ack();

        // gravity and soft-drop expiry on the same edge
        tick_n(9);
        chk("tie_pre_ticks", 32'(drop_if.drop_req), 32'd0);
        soft_drop = 1'b1;
        repeat (3) step();
        chk("tie_pre_soft", 32'(drop_if.drop_req), 32'd0);
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
        soft_drop = 1'b0;
        chk("tie_req", 32'(drop_if.drop_req), 32'd1);
        chk("tie_src_gravity", 32'(drop_if.drop_src), 32'd0);
        ack();
        chk("tie_ack", 32'(drop_if.drop_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/gravity_timer.md
Name: gravity_timer

Overview:
- Downstream consumer of the game-tick enable pulse (one `clk` cycle per game tick).
- Converts ticks into piece-drop requests to the game FSM:
  - gravity period shrinks as level rises;
  - soft-drop path bypasses ticks;
  - level/line bookkeeping driven by line-clear reports.
- Drop requests use a req/ack handshake with the piece-control FSM.

Parameters:
- BASE_TICKS, 10: gravity period in ticks at level 0; must be ≥ MAX_LEVEL+1.
- MAX_LEVEL, 9: level saturation value; ≤ 31.
- LINES_PER_LEVEL, 10: cleared lines per level increment; must be ≥ 4.
- SOFT_CYCLES, 5_000_000: `clk` cycles between soft-drop requests; ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick_en  in  1  single-cycle game-tick pulse from the game clock divider
- run  in  1  level-sensitive; 1 = game active, 0 = paused/stopped
- new_game  in  1  single-cycle pulse; restart level/line state
- soft_drop  in  1  level-sensitive soft-drop button (debounced upstream)
- drop_ack  in  1  FSM consumed the pending drop
- lines_valid  in  1  single-cycle pulse; lines_num valid
- lines_num  in  3  lines cleared by the last lock, 0..4; values >4 clamp to 4
- drop_req  out  1  drop pending; held until acked
- drop_src  out  1  0 = gravity, 1 = soft drop; valid while drop_req=1
- level  out  5  current level, 0..MAX_LEVEL
- lines_total  out  16  total cleared lines, saturates at 65535
- level_up  out  1  one-cycle pulse on level increment

Behaviour:
Reset (rst_n=0 at posedge):
- state=IDLE.
- drop_req=0, drop_src=0, level=0, lines_total=0, level_up=0.
- tick_cnt=0, soft_cnt=0, line_acc=0.

Period:
- period = BASE_TICKS − level.
- Recomputed combinationally every cycle from the current level.

States:
- IDLE:
  - Counters held at 0; drop_req=0.
  - run=1 → COUNT on the next edge.
- COUNT:
  - On tick_en: if tick_cnt+1 ≥ period → REQ with drop_src=0 and tick_cnt←0; else tick_cnt++.
  - While soft_drop=1: soft_cnt++. At soft_cnt == SOFT_CYCLES−1 → REQ with drop_src=1, soft_cnt←0.
  - soft_drop=0 clears soft_cnt the same cycle.
  - Both conditions in the same cycle: gravity wins (drop_src=0), and both counters clear.
- REQ:
  - drop_req=1 registered, asserted the cycle after the triggering edge.
  - drop_src stable while in REQ.
  - tick_en ignored; ticks are not accumulated; tick_cnt held at 0.
  - soft_cnt held at 0.
  - drop_ack=1 → COUNT; drop_req=0 on the next cycle.
  - drop_ack while not in REQ is ignored.

Global overrides:
- run=0 in any state → IDLE next edge:
  - drop_req drops; tick_cnt and soft_cnt clear.
  - level, lines_total and line_acc retained.
- new_game=1 (priority over run and lines_valid):
  - level←0, lines_total←0, line_acc←0, tick_cnt←0, soft_cnt←0, drop_req←0.
  - Next state: COUNT if run=1, else IDLE.

Lines and level (independent of FSM state, except new_game):
- On lines_valid: n = min(lines_num, 4).
- lines_total ← sat16(lines_total + n).
- sum = line_acc + n.
  - If sum ≥ LINES_PER_LEVEL: line_acc ← sum − LINES_PER_LEVEL; level ← min(level+1, MAX_LEVEL).
  - level_up=1 for one cycle, only if level actually changed.
  - Else line_acc ← sum.
- At MAX_LEVEL: line_acc still wraps; no level_up.
- Level change mid-count: tick_cnt is not cleared; if tick_cnt ≥ new period−1, the next tick fires.
- lines_valid with n=0 changes nothing.

Test Plan:
1. Reset, run=1, no soft drop, tick_en every 8 clk: first drop_req rises 1 clk after the 10th tick, drop_src=0. Ack 3 clk later → drop_req low next clk; the next request follows 10 ticks after the ack.
2. Hold drop_ack=0 across 25 ticks: drop_req stays 1, drop_src unchanged. After ack, a fresh 10-tick count starts, with no burst of queued drops.
3. SOFT_CYCLES=4, soft_drop=1, no ticks: drop_req at clk 4 with drop_src=1; ack immediately → next request 4 clk later. Release soft_drop at soft_cnt=2 → no request.
4. Line events 4,4,2: lines_total=10, level 0→1, single level_up pulse, line_acc=0, period=9. Then 4,4,4: level=2, line_acc=2.
5. Drive level to MAX_LEVEL=9 with 100 lines: period=1, a drop every tick. A further 10 lines: level stays 9, no level_up, lines_total=110.
6. In REQ: run=0 → drop_req=0 next clk, state IDLE, level kept. new_game with run=1 → level=0, lines_total=0, COUNT, 10-tick period restored. Tick coincident with soft-drop expiry → drop_src=0.
